// File: rtl/status_pio_pkg.sv
// Shared constants for the status PIO slave: register map, edge modes and
// interrupt source selection.
package status_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int IRQ_FROM_EDGE  = 0;
   localparam int IRQ_FROM_LEVEL = 1;

endpackage

// File: rtl/status_pio_sync.sv
// Per-bit flop chain bringing the asynchronous status bus into clk.
// With zero stages the input is assumed already synchronous and passed through.
module status_pio_sync #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign q = d;
      end else begin : g_chain
         logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_r;

         // Shift the input through the synchroniser stages.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               chain_r <= '0;
            end else begin
               chain_r[0] <= d;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  chain_r[i] <= chain_r[i-1];
               end
            end
         end

         assign q = chain_r[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/status_pio_irq.sv
// Avalon-MM status input port: live synchronised data, sticky W1C edge capture,
// interrupt mask and a registered interrupt request.
module status_pio_irq
   import status_pio_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0,
   parameter int IRQ_LEVEL   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] edge_raw_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] w1c_s;
   logic [WIDTH-1:0] edgecap_r;
   logic [WIDTH-1:0] edgecap_nxt_s;
   logic [WIDTH-1:0] irqmask_r;
   logic [2:0]       arm_cnt_r;
   logic             armed_s;
   logic             wr_mask_s;
   logic             wr_edge_s;
   logic [31:0]      rd_mux_s;
   logic             irq_nxt_s;
   logic             unused_wd_s;

   // Upper write-data bits beyond WIDTH carry no meaning.
   assign unused_wd_s = ^writedata;

   status_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_s)
   );

   assign wr_mask_s = write && (address == ADDR_IRQMASK);
   assign wr_edge_s = write && (address == ADDR_EDGECAP);
   assign armed_s   = (arm_cnt_r == ARM_MAX);

   // Raw edge vector for the configured edge mode.
   always_comb begin
      edge_raw_s = {WIDTH{1'b0}};
      case (EDGE_TYPE)
         EDGE_RISING:  edge_raw_s = sync_s & ~prev_r;
         EDGE_FALLING: edge_raw_s = ~sync_s & prev_r;
         EDGE_ANY:     edge_raw_s = sync_s ^ prev_r;
         default:      edge_raw_s = {WIDTH{1'b0}};
      endcase
   end

   // Gate edges until the chain has flushed the reset state, and build the
   // capture update where a new edge beats a simultaneous clear.
   always_comb begin
      edge_s        = {WIDTH{1'b0}};
      w1c_s         = {WIDTH{1'b0}};
      edgecap_nxt_s = edgecap_r;
      if (armed_s) begin
         edge_s = edge_raw_s;
      end else begin
         edge_s = {WIDTH{1'b0}};
      end
      if (wr_edge_s) begin
         w1c_s = writedata[WIDTH-1:0];
      end else begin
         w1c_s = {WIDTH{1'b0}};
      end
      edgecap_nxt_s = edge_s | (edgecap_r & ~w1c_s);
   end

   // Read mux; unused upper bits stay zero.
   always_comb begin
      rd_mux_s = 32'd0;
      case (address)
         ADDR_DATA:    rd_mux_s[WIDTH-1:0] = sync_s;
         ADDR_RSVD:    rd_mux_s = 32'd0;
         ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irqmask_r;
         ADDR_EDGECAP: rd_mux_s[WIDTH-1:0] = edgecap_r;
         default:      rd_mux_s = 32'd0;
      endcase
   end

   // Interrupt source selection.
   always_comb begin
      irq_nxt_s = 1'b0;
      if (IRQ_LEVEL == IRQ_FROM_LEVEL) begin
         irq_nxt_s = |(sync_s & irqmask_r);
      end else begin
         irq_nxt_s = |(edgecap_r & irqmask_r);
      end
   end

   // Arm counter saturates once prev has seen a fully synchronised sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_cnt_r <= 3'd0;
      end else if (arm_cnt_r != ARM_MAX) begin
         arm_cnt_r <= arm_cnt_r + 3'd1;
      end
   end

   // Edge history, capture register and mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r    <= {WIDTH{1'b0}};
         edgecap_r <= {WIDTH{1'b0}};
         irqmask_r <= {WIDTH{1'b0}};
      end else begin
         prev_r    <= sync_s;
         edgecap_r <= edgecap_nxt_s;
         if (wr_mask_s) begin
            irqmask_r <= writedata[WIDTH-1:0];
         end
      end
   end

   // Registered bus-facing outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'd0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_mux_s;
         irq      <= irq_nxt_s;
      end
   end

endmodule
